// File: rtl/eth_phy_66b_pkg.sv
// Shared 64b/66b definitions for the 10G PHY transmit and receive paths:
// sync header codes, the block-sync FSM state encoding and the scrambler
// polynomial taps (1 + x^39 + x^58).
package eth_phy_66b_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    typedef enum logic [1:0] {
        HUNT   = 2'b00,
        SLIP   = 2'b01,
        LOCKED = 2'b10
    } sync_state_e;

    localparam int SCR_TAP_A = 39;
    localparam int SCR_TAP_B = 58;

    // Only the two codes with a transition are legal sync headers.
    function automatic logic sync_hdr_valid(input logic [1:0] hdr);
        return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
    endfunction

endpackage

// File: rtl/eth_phy_66b_descrambler.sv
// Self-synchronizing 64b/66b payload descrambler, polynomial 1 + x^39 + x^58,
// LSB first. The 58-bit history holds the most recently received scrambled
// bits (bit 57 newest) and advances only when en is high.
module eth_phy_66b_descrambler
    import eth_phy_66b_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] scr_data,
    output logic [DATA_WIDTH-1:0] data
);

    logic [SCR_TAP_B-1:0]            state;
    logic [DATA_WIDTH+SCR_TAP_B-1:0] hist;

    // Old history below, current block above: hist[SCR_TAP_B + i] is bit i.
    assign hist = {scr_data, state};

    // Each output bit removes the two tap contributions from the received line.
    always_comb begin
        data = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            data[i] = scr_data[i] ^ hist[i + SCR_TAP_B - SCR_TAP_A] ^ hist[i];
        end
    end

    // History register keeps the newest SCR_TAP_B received bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= '1;
        end else if (en) begin
            // NOTE: clocked state is assigned with <= so every register samples pre-edge values.
            state <= hist[DATA_WIDTH+SCR_TAP_B-1:DATA_WIDTH];
        end
    end

endmodule

// File: rtl/eth_phy_66b_rx_sync.sv
// Receive 64b/66b block synchronizer: hunts for block alignment via gearbox
// bitslips, declares/monitors block lock and forwards blocks once locked.
// Build option: define ETH_PHY_66B_RX_DESCRAMBLE_EN to descramble the payload;
// without it the payload is forwarded as received.
module eth_phy_66b_rx_sync
    import eth_phy_66b_pkg::*;
#(
    parameter int DATA_WIDTH          = 64,
    parameter int HDR_WIDTH           = 2,
    parameter int LOCK_COUNT          = 64,
    parameter int INVALID_LIMIT       = 16,
    parameter int BITSLIP_HIGH_CYCLES = 1,
    parameter int BITSLIP_LOW_CYCLES  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] serdes_rx_data,
    input  logic [HDR_WIDTH-1:0]  serdes_rx_hdr,
    input  logic                  serdes_rx_valid,
    output logic                  serdes_rx_bitslip,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic [HDR_WIDTH-1:0]  rx_hdr,
    output logic                  rx_valid,
    output logic                  rx_block_lock,
    output logic                  rx_bad_block
);

    localparam int CNT_W  = $clog2(LOCK_COUNT + 1);
    localparam int INV_W  = $clog2(INVALID_LIMIT + 1);
    localparam int SLIP_W = $clog2(BITSLIP_HIGH_CYCLES + BITSLIP_LOW_CYCLES + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(LOCK_COUNT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(LOCK_COUNT);
    localparam logic [INV_W-1:0]  INV_LAST  = INV_W'(INVALID_LIMIT - 1);
    localparam logic [INV_W-1:0]  INV_MAX   = INV_W'(INVALID_LIMIT);
    localparam logic [SLIP_W-1:0] SLIP_LAST = SLIP_W'(BITSLIP_HIGH_CYCLES + BITSLIP_LOW_CYCLES - 1);
    localparam logic [SLIP_W-1:0] SLIP_HIGH = SLIP_W'(BITSLIP_HIGH_CYCLES);

    sync_state_e       state, state_nxt;
    logic [CNT_W-1:0]  sh_cnt, sh_cnt_nxt, sh_cnt_inc;
    logic [INV_W-1:0]  sh_invalid_cnt, sh_invalid_nxt, sh_invalid_inc;
    logic [SLIP_W-1:0] slip_cnt, slip_cnt_nxt;
    logic              eval;
    logic              hdr_ok;
    logic              lose_lock;
    logic [DATA_WIDTH-1:0] data_out;

    // A block is evaluated only when strobed and not inside the slip/ignore window.
    assign eval   = serdes_rx_valid && (state != SLIP);
    assign hdr_ok = sync_hdr_valid(serdes_rx_hdr);

    // Saturating increments: the counters can never wrap back to zero.
    assign sh_cnt_inc     = (sh_cnt == CNT_MAX) ? sh_cnt : sh_cnt + CNT_W'(1);
    assign sh_invalid_inc = (sh_invalid_cnt == INV_MAX) ? sh_invalid_cnt
                                                        : sh_invalid_cnt + INV_W'(1);

`ifdef ETH_PHY_66B_RX_DESCRAMBLE_EN
    eth_phy_66b_descrambler #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_descrambler (
        .clk      (clk),
        .rst      (rst),
        .en       (eval),
        .scr_data (serdes_rx_data),
        .data     (data_out)
    );
`else
    assign data_out = serdes_rx_data;
`endif

    // Block-sync FSM and header counters; the slip timer runs on clock cycles.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_nxt      = state;
        sh_cnt_nxt     = sh_cnt;
        sh_invalid_nxt = sh_invalid_cnt;
        slip_cnt_nxt   = slip_cnt;
        lose_lock      = 1'b0;
        case (state)
            HUNT: begin
                if (eval) begin
                    if (!hdr_ok) begin
                        state_nxt    = SLIP;
                        slip_cnt_nxt = '0;
                    end else if (sh_cnt == CNT_LAST) begin
                        state_nxt      = LOCKED;
                        sh_cnt_nxt     = '0;
                        sh_invalid_nxt = '0;
                    end else begin
                        sh_cnt_nxt = sh_cnt_inc;
                    end
                end
            end
            SLIP: begin
                if (slip_cnt == SLIP_LAST) begin
                    state_nxt      = HUNT;
                    sh_cnt_nxt     = '0;
                    sh_invalid_nxt = '0;
                    slip_cnt_nxt   = '0;
                end else begin
                    slip_cnt_nxt = slip_cnt + SLIP_W'(1);
                end
            end
            LOCKED: begin
                if (eval) begin
                    // Losing lock wins over a coinciding window end.
                    if (!hdr_ok && (sh_invalid_cnt == INV_LAST)) begin
                        lose_lock    = 1'b1;
                        state_nxt    = SLIP;
                        slip_cnt_nxt = '0;
                    end else if (sh_cnt == CNT_LAST) begin
                        sh_cnt_nxt     = '0;
                        sh_invalid_nxt = '0;
                    end else begin
                        sh_cnt_nxt = sh_cnt_inc;
                        if (!hdr_ok) begin
                            sh_invalid_nxt = sh_invalid_inc;
                        end
                    end
                end
            end
            default: begin
                state_nxt = HUNT;
            end
        endcase
    end

    // State, counters and the registered output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= HUNT;
            sh_cnt            <= '0;
            sh_invalid_cnt    <= '0;
            slip_cnt          <= '0;
            serdes_rx_bitslip <= 1'b0;
            rx_data           <= '0;
            rx_hdr            <= '0;
            rx_valid          <= 1'b0;
            rx_bad_block      <= 1'b0;
        end else begin
            state             <= state_nxt;
            sh_cnt            <= sh_cnt_nxt;
            sh_invalid_cnt    <= sh_invalid_nxt;
            slip_cnt          <= slip_cnt_nxt;
            serdes_rx_bitslip <= (state_nxt == SLIP) && (slip_cnt_nxt < SLIP_HIGH);
            rx_valid          <= eval && (state == LOCKED) && !lose_lock;
            rx_bad_block      <= eval && !hdr_ok;
            if (eval) begin
                rx_data <= data_out;
                rx_hdr  <= serdes_rx_hdr;
            end
        end
    end

    assign rx_block_lock = (state == LOCKED);

endmodule

// File: tb/tb_eth_phy_66b_rx_sync.sv
// Self-checking bench for eth_phy_66b_rx_sync: table-driven hunt/slip/lock
// vectors plus hand-written loss-of-lock, descramble and reset sequences.
module tb_eth_phy_66b_rx_sync;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] serdes_rx_data;
    logic [1:0]  serdes_rx_hdr;
    logic        serdes_rx_valid;
    logic        serdes_rx_bitslip;
    logic [63:0] rx_data;
    logic [1:0]  rx_hdr;
    logic        rx_valid;
    logic        rx_block_lock;
    logic        rx_bad_block;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    eth_phy_66b_rx_sync dut (
        .clk               (clk),
        .rst               (rst),
        .serdes_rx_data    (serdes_rx_data),
        .serdes_rx_hdr     (serdes_rx_hdr),
        .serdes_rx_valid   (serdes_rx_valid),
        .serdes_rx_bitslip (serdes_rx_bitslip),
        .rx_data           (rx_data),
        .rx_hdr            (rx_hdr),
        .rx_valid          (rx_valid),
        .rx_block_lock     (rx_block_lock),
        .rx_bad_block      (rx_bad_block)
    );

    typedef struct {
        logic       v;
        logic [1:0] hdr;
        logic       exp_lock;
        logic       exp_rxv;
        logic       exp_bad;
        logic       exp_slip;
    } vec_t;

    vec_t vecs[$];

    // Transmit scrambler reference state (newest scrambled bit at index 57).
    logic [57:0] tx_state;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_ctl(input string tag, input logic el, input logic ev,
                             input logic eb, input logic es);
        check($sformatf("%s lock", tag), 64'(rx_block_lock), 64'(el));
        check($sformatf("%s rx_valid", tag), 64'(rx_valid), 64'(ev));
        check($sformatf("%s bad_block", tag), 64'(rx_bad_block), 64'(eb));
        check($sformatf("%s bitslip", tag), 64'(serdes_rx_bitslip), 64'(es));
    endtask

    task automatic drive(input logic v, input logic [1:0] h, input logic [63:0] d);
        serdes_rx_valid = v;
        serdes_rx_hdr   = h;
        serdes_rx_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic v, input logic [1:0] h, input logic el,
                           input logic ev, input logic eb, input logic es);
        vec_t t;
        t.v = v; t.hdr = h; t.exp_lock = el; t.exp_rxv = ev; t.exp_bad = eb; t.exp_slip = es;
        vecs.push_back(t);
    endtask

    // Scrambler as on the transmit side: feedback from its own scrambled output.
    function automatic logic [63:0] scramble_next(input logic [63:0] d);
        logic [121:0] h;
        h = '0;
        h[57:0] = tx_state;
        for (int i = 0; i < 64; i++) begin
            h[58 + i] = d[i] ^ h[i + 19] ^ h[i];
        end
        tx_state = h[121:64];
        return h[121:58];
    endfunction

    initial begin
        logic [63:0] scr;
        logic [63:0] exp_data;
        logic [1:0]  h;
        int          nv;
        bit          inv;

        rst = 1'b1;
        serdes_rx_valid = 1'b0;
        serdes_rx_hdr   = 2'b00;
        serdes_rx_data  = '0;

        // Hunt: 9 good headers, 10th invalid, then the 1+8 cycle slip window.
        for (int i = 0; i < 9; i++) add_vec(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) add_vec(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        // Reacquire from a cleared counter with a gap every 3rd cycle.
        nv = 0;
        for (int r = 0; nv < 64; r++) begin
            if (r % 3 == 2) begin
                add_vec(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
            end else begin
                nv++;
                add_vec(1'b1, (nv % 2 == 0) ? 2'b10 : 2'b01, (nv == 64), 1'b0, 1'b0, 1'b0);
            end
        end
        add_vec(1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        add_vec(1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);

        // Reset with random input: all outputs must read zero.
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom), 2'($urandom), {$urandom, $urandom});
            check_ctl($sformatf("reset%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
            check("reset rx_data", rx_data, 64'h0);
            check("reset rx_hdr", 64'(rx_hdr), 64'h0);
        end
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].v, vecs[i].hdr, 64'(i));
            check_ctl($sformatf("vec%0d", i), vecs[i].exp_lock, vecs[i].exp_rxv,
                      vecs[i].exp_bad, vecs[i].exp_slip);
        end

        // Locked with one block already in the window: 63 more close it with 15 invalid.
        for (int i = 0; i < 63; i++) begin
            inv = (i < 15);
            drive(1'b1, inv ? ((i % 2 == 0) ? 2'b00 : 2'b11) : 2'b01, 64'(i));
            check_ctl($sformatf("win1_%0d", i), 1'b1, 1'b1, inv, 1'b0);
        end
        // Next window: invalid count restarted, so lock survives until the 16th.
        for (int j = 0; j < 20; j++) begin
            inv = (j < 15) || (j == 19);
            drive(1'b1, inv ? 2'b11 : 2'b10, 64'(j));
            if (j < 19) check_ctl($sformatf("win2_%0d", j), 1'b1, 1'b1, inv, 1'b0);
            else        check_ctl("lose_lock", 1'b0, 1'b0, 1'b1, 1'b1);
        end
        drive(1'b1, 2'b00, 64'h0);
        check_ctl("slip_low", 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of the slip window.
        rst = 1'b1;
        drive(1'b1, 2'b00, 64'h1234);
        check_ctl("rst_mid_slip", 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_mid_slip rx_data", rx_data, 64'h0);
        drive(1'b1, 2'b01, 64'h5678);
        rst = 1'b0;

        // Scrambled all-zero payload, both ends seeded all ones; gaps carry junk.
        tx_state = '1;
        nv = 0;
        exp_data = '0;
        for (int r = 0; nv < 76; r++) begin
            if (r % 4 == 3) begin
                drive(1'b0, 2'b00, 64'hDEAD_BEEF_CAFE_F00D);
                if (nv > 64) begin
                    check("gap rx_valid", 64'(rx_valid), 64'h0);
                    check("gap rx_data hold", rx_data, exp_data);
                end
            end else begin
                nv++;
                h = (nv % 3 == 0) ? 2'b10 : 2'b01;
                scr = scramble_next(64'h0);
`ifdef ETH_PHY_66B_RX_DESCRAMBLE_EN
                exp_data = 64'h0;
`else
                exp_data = scr;
`endif
                drive(1'b1, h, scr);
                check($sformatf("desc%0d bitslip", nv), 64'(serdes_rx_bitslip), 64'h0);
                if (nv == 63) check("desc lock before 64", 64'(rx_block_lock), 64'h0);
                if (nv == 64) begin
                    check("desc lock at 64", 64'(rx_block_lock), 64'h1);
                    check("desc no fwd at 64", 64'(rx_valid), 64'h0);
                end
                if (nv > 64) begin
                    check($sformatf("desc%0d rx_valid", nv), 64'(rx_valid), 64'h1);
                    check($sformatf("desc%0d rx_data", nv), rx_data, exp_data);
                    check($sformatf("desc%0d rx_hdr", nv), 64'(rx_hdr), 64'(h));
                end
            end
        end

        // Reset while locked and forwarding.
        rst = 1'b1;
        drive(1'b1, 2'b01, 64'hFFFF);
        check_ctl("rst_mid_lock", 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_mid_lock rx_data", rx_data, 64'h0);
        check("rst_mid_lock rx_hdr", 64'(rx_hdr), 64'h0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b01, 64'(i));
            check_ctl($sformatf("post_rst%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
